// File: rtl/node_act_feeder_pkg.sv
// Shared constants and fill-side state type for the layer-4 activation feeder.
package node_act_feeder_pkg;
   localparam int NODE_FANIN = 15;
   localparam int ACT_W      = 8;
   localparam int NODE_LAT   = 3;

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} fill_state_e;
endpackage

// File: rtl/node_act_if.sv
// Activation stream in, parallel node-input frame out.
interface node_act_if
   import node_act_feeder_pkg::*;
#(
   parameter int N_IN = NODE_FANIN,
   parameter int DW   = ACT_W
);
   logic [DW-1:0]      s_data;
   logic               s_valid;
   logic               s_last;
   logic               s_ready;
   logic [N_IN*DW-1:0] a_bus;
   logic               a_valid;
   logic               frame_err;
   logic               busy;

   modport slave  (input  s_data, s_valid, s_last,
                   output s_ready, a_bus, a_valid, frame_err, busy);
   modport master (output s_data, s_valid, s_last,
                   input  s_ready, a_bus, a_valid, frame_err, busy);
endinterface

// File: rtl/node_act_hold_ctr.sv
// Loadable saturating down-counter; zero marks the end of the output hold window.
module node_act_hold_ctr
   import node_act_feeder_pkg::*;
#(
   parameter int HOLD = NODE_LAT
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic zero
);
   localparam int W = (HOLD < 2) ? 1 : $clog2(HOLD);

   logic [W-1:0] cnt;

   // The strobe cycle itself is the first held cycle, so HOLD-1 remain after it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             cnt <= '0;
      else if (load)         cnt <= W'(HOLD - 1);
      else if (cnt != '0)    cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/node_act_feeder.sv
// Streaming-to-parallel activation feeder: fills a shadow frame, then transfers it
// to a held output bus with a one-cycle strobe while the next frame loads.
module node_act_feeder
   import node_act_feeder_pkg::*;
#(
   parameter int N_IN = NODE_FANIN,
   parameter int DW   = ACT_W,
   parameter int HOLD = NODE_LAT
) (
   input logic       clk,
   input logic       reset,
   node_act_if.slave bus
);
   localparam int IW = $clog2(N_IN);
   localparam logic [0:0] ST_FILL = FILL;
   localparam logic [0:0] ST_FULL = FULL;

   logic [0:0]                 state;
   logic [IW-1:0]              idx;
   logic [N_IN-1:0][DW-1:0]    shadow;
   logic [N_IN-1:0][DW-1:0]    a_reg;
   logic                       a_valid_q;
   logic                       frame_err_q;
   logic                       accept, at_end, xfer, hold_zero;

   assign bus.s_ready = (state == ST_FILL);
   assign accept      = bus.s_valid && bus.s_ready;
   assign at_end      = (idx == IW'(N_IN - 1));
   assign xfer        = (state == ST_FULL) && hold_zero;

   node_act_hold_ctr #(.HOLD(HOLD)) u_hold (
      .clk  (clk),
      .reset(reset),
      .load (xfer),
      .zero (hold_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_FILL;
         idx         <= '0;
         shadow      <= '0;
         a_reg       <= '0;
         a_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         a_valid_q   <= xfer;
         frame_err_q <= 1'b0;
         if (xfer) begin
            a_reg <= shadow;
            state <= ST_FILL;
            idx   <= '0;
         end else if (accept) begin
            if (at_end) begin
               // A missing last still completes the frame; only the error is flagged.
               shadow[idx] <= bus.s_data;
               state       <= ST_FULL;
               frame_err_q <= !bus.s_last;
            end else if (bus.s_last) begin
               idx         <= '0;
               frame_err_q <= 1'b1;
            end else begin
               shadow[idx] <= bus.s_data;
               idx         <= idx + IW'(1);
            end
         end
      end
   end

   assign bus.a_bus     = a_reg;
   assign bus.a_valid   = a_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state == ST_FULL) || (idx != '0) || !hold_zero;
endmodule
